mux4_scan_ctrl: RTL and testbench

- Sequencer directly upstream of the 8-bit 4:1 multiplexer; drives its `sel` and samples its `y`.
- On `start`, visits each enabled channel in ascending index order.
- For each channel: waits a settle time, then presents the captured mux output and channel index on a valid/ready output port.
- Turns the combinational mux into a paced, handshaked sample stream for downstream logic.

---
 rtl/mux4_scan_ctrl_if.sv | 24 ++
 rtl/mux4_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_mux4_scan_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_scan_ctrl_if.sv
// Sample stream port of mux4_scan_ctrl: captured mux data
// plus its channel index, with a valid/ready handshake.
interface mux4_scan_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_chan;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_chan,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_chan,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Paced scan sequencer for a 4:1 mux: settle, sample, hand off.
// Optional macro SCAN_CONT_EN: continuous wrap-around with stop.
module mux4_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       chan_en,
    input  logic [WIDTH-1:0] y,
`ifdef SCAN_CONT_EN
    input  logic             stop,
`endif
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    mux4_scan_ctrl_if.master stream
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0] RELOAD = 4'(DWELL - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] mask;
    logic [3:0] above;
    logic       has_next;
    logic       fin;
    logic [1:0] nxt;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else if (m[3]) r = 2'd3;
        return r;
    endfunction

    function automatic logic [3:0] higher(input logic [1:0] s);
        logic [3:0] r;
        unique case (s)
            2'd0:    r = 4'b1110;
            2'd1:    r = 4'b1100;
            2'd2:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

`ifdef SCAN_CONT_EN
    logic stop_q;
`endif

    always_comb begin
        above    = mask & higher(sel);
        has_next = |above;
`ifdef SCAN_CONT_EN
        // Continuous mode only ends on a latched stop; otherwise wrap.
        fin = stop_q;
        nxt = has_next ? low_idx(above) : low_idx(mask);
`else
        fin = !has_next;
        nxt = low_idx(above);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            sel              <= 2'd0;
            cnt              <= 4'd0;
            mask             <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stream.out_data  <= '0;
            stream.out_chan  <= 2'd0;
            stream.out_valid <= 1'b0;
`ifdef SCAN_CONT_EN
            stop_q           <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SCAN_CONT_EN
            if (busy && stop)
                stop_q <= 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (|chan_en) begin
                            mask  <= chan_en;
                            sel   <= low_idx(chan_en);
                            cnt   <= RELOAD;
                            busy  <= 1'b1;
                            state <= SETTLE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        stream.out_data  <= y;
                        stream.out_chan  <= sel;
                        stream.out_valid <= 1'b1;
                        state            <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (stream.out_ready) begin
                        stream.out_valid <= 1'b0;
                        if (fin) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
`ifdef SCAN_CONT_EN
                            stop_q <= 1'b0;
`endif
                        end else begin
                            sel   <= nxt;
                            cnt   <= RELOAD;
                            state <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl with a behavioural 4:1 mux.
// Inputs change 1ns after posedge; outputs observed on negedge.
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] chan_en;
    logic [7:0] y;
    logic [1:0] sel;
    logic       busy;
    logic       done;
`ifdef SCAN_CONT_EN
    logic       stop;
`endif

    mux4_scan_ctrl_if #(.WIDTH(8)) stream ();

    mux4_scan_ctrl #(.WIDTH(8), .DWELL(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .chan_en (chan_en),
        .y       (y),
`ifdef SCAN_CONT_EN
        .stop    (stop),
`endif
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .stream  (stream.master)
    );

    always #5 clk = ~clk;

    logic [7:0] dmem [4];
    assign y = dmem[sel];

    int compared;
    int mismatched;

    int   cyc;
    int   ndone;
    int   bothhigh;
    int   selbad;
    bit   chk_sel;
    logic [1:0] bchan [$];
    logic [7:0] bdata [$];
    int         bcyc  [$];

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (stream.out_valid && stream.out_ready) begin
                bchan.push_back(stream.out_chan);
                bdata.push_back(stream.out_data);
                bcyc.push_back(cyc);
            end
            if (done) ndone++;
            if (done && busy) bothhigh++;
            if (chk_sel && busy && (sel == 2'd0 || sel == 2'd2))
                selbad++;
        end
    end

    task automatic clear_log();
        bchan.delete();
        bdata.delete();
        bcyc.delete();
        ndone = 0;
    endtask

    task automatic drive_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        drive_tick();
        start = 1'b1;
        drive_tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL %s_done_timeout: done=0 required 1", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        chan_en = 4'd0;
        stream.out_ready = 1'b0;
`ifdef SCAN_CONT_EN
        stop = 1'b0;
`endif
        repeat (2) @(negedge clk);
        compared++;
        if (sel !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_sel: got %0d required 0", sel);
        end
        compared++;
        if (stream.out_data !== 8'h00 || stream.out_chan !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_data: got %h/%0d required 00/0",
                     stream.out_data, stream.out_chan);
        end
        compared++;
        if ({stream.out_valid, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b required 000",
                     {stream.out_valid, busy, done});
        end
        drive_tick();
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_beats(input string name, input int n,
                               input logic [1:0] ch [4]);
        compared++;
        if (bchan.size() != n) begin
            mismatched++;
            $display("FAIL %s_count: got %0d beats required %0d",
                     name, bchan.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                compared++;
                if (bchan[i] !== ch[i] || bdata[i] !== dmem[ch[i]]) begin
                    mismatched++;
                    $display("FAIL %s_beat%0d: got (%0d,%h) required (%0d,%h)",
                             name, i, bchan[i], bdata[i], ch[i], dmem[ch[i]]);
                end
            end
        end
        compared++;
        if (ndone != 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_end: got done_pulses=%0d busy=%b required 1/0",
                     name, ndone, busy);
        end
    endtask

    task automatic test_single_pass();
        logic [1:0] ch [4];
        ch = '{2'd0, 2'd1, 2'd2, 2'd3};
        clear_log();
        chan_en = 4'b1111;
        stream.out_ready = 1'b1;
        pulse_start();
        wait_done("single");
        check_beats("single", 4, ch);
        if (bcyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                compared++;
                if (bcyc[i] - bcyc[i-1] != 3) begin
                    mismatched++;
                    $display("FAIL single_spacing%0d: got %0d required 3",
                             i, bcyc[i] - bcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_sparse();
        logic [1:0] ch [4];
        ch = '{2'd1, 2'd3, 2'd0, 2'd0};
        clear_log();
        selbad = 0;
        chan_en = 4'b1010;
        stream.out_ready = 1'b1;
        chk_sel = 1'b1;
        pulse_start();
        wait_done("sparse");
        chk_sel = 1'b0;
        check_beats("sparse", 2, ch);
        compared++;
        if (selbad != 0) begin
            mismatched++;
            $display("FAIL sparse_sel: got %0d bad cycles required 0", selbad);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] ch [4];
        bit seen;
        ch = '{2'd0, 2'd1, 2'd2, 2'd3};
        clear_log();
        chan_en = 4'b1111;
        stream.out_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (stream.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL bp_valid_timeout: out_valid=0 required 1");
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (stream.out_data !== 8'hA0 || stream.out_chan !== 2'd0 ||
                sel !== 2'd0 || stream.out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_hold%0d: got data=%h chan=%0d sel=%0d v=%b required A0/0/0/1",
                         i, stream.out_data, stream.out_chan, sel,
                         stream.out_valid);
            end
            @(negedge clk);
        end
        drive_tick();
        stream.out_ready = 1'b1;
        wait_done("bp");
        check_beats("bp", 4, ch);
    endtask

    task automatic test_empty();
        clear_log();
        chan_en = 4'b0000;
        stream.out_ready = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);
        compared++;
        if (ndone != 1 || bchan.size() != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL empty: got pulses=%0d beats=%0d busy=%b required 1/0/0",
                     ndone, bchan.size(), busy);
        end
    endtask

    task automatic test_ignored_start();
        logic [1:0] ch [4];
        ch = '{2'd0, 2'd1, 2'd2, 2'd3};
        clear_log();
        chan_en = 4'b1111;
        stream.out_ready = 1'b1;
        pulse_start();
        repeat (3) drive_tick();
        chan_en = 4'b0001;
        pulse_start();
        wait_done("restart");
        check_beats("restart", 4, ch);
    endtask

    task automatic test_reset_mid();
        logic [1:0] ch [4];
        bit seen;
        ch = '{2'd0, 2'd1, 2'd2, 2'd3};
        clear_log();
        chan_en = 4'b1111;
        stream.out_ready = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sel == 2'd2) begin
                seen = 1'b1;
                break;
            end
        end
        drive_tick();
        stream.out_ready = 1'b0;
        for (int i = 0; i < 10 && seen; i++) begin
            @(negedge clk);
            if (stream.out_valid && stream.out_chan == 2'd2) break;
        end
        compared++;
        if (!seen || !(stream.out_valid && stream.out_chan == 2'd2)) begin
            mismatched++;
            $display("FAIL rstmid_hold2: got v=%b chan=%0d required 1/2",
                     stream.out_valid, stream.out_chan);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (sel !== 2'd0 || stream.out_data !== 8'h00 ||
            stream.out_chan !== 2'd0 ||
            {stream.out_valid, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL rstmid_async: got sel=%0d data=%h chan=%0d flags=%b required 0/00/0/000",
                     sel, stream.out_data, stream.out_chan,
                     {stream.out_valid, busy, done});
        end
        repeat (2) drive_tick();
        stream.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (ndone != 0) begin
            mismatched++;
            $display("FAIL rstmid_nodone: got %0d pulses required 0", ndone);
        end
        clear_log();
        pulse_start();
        wait_done("rstmid");
        check_beats("rstmid", 4, ch);
    endtask

`ifdef SCAN_CONT_EN
    task automatic test_cont();
        logic [1:0] exp;
        bit found;
        int n;
        clear_log();
        chan_en = 4'b0011;
        stream.out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 60 && bchan.size() < 5; i++)
            @(negedge clk);
        compared++;
        if (bchan.size() < 5) begin
            mismatched++;
            $display("FAIL cont_count: got %0d beats required 5",
                     bchan.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp = 2'(i % 2);
                compared++;
                if (bchan[i] !== exp || bdata[i] !== dmem[exp]) begin
                    mismatched++;
                    $display("FAIL cont_beat%0d: got (%0d,%h) required (%0d,%h)",
                             i, bchan[i], bdata[i], exp, dmem[exp]);
                end
            end
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && sel == 2'd0 && !stream.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        n = bchan.size();
        drive_tick();
        stop = 1'b1;
        drive_tick();
        stop = 1'b0;
        wait_done("cont");
        compared++;
        if (!found || bchan.size() != n + 1 ||
            bchan[bchan.size()-1] !== 2'd0 ||
            bdata[bdata.size()-1] !== 8'hA0) begin
            mismatched++;
            $display("FAIL cont_stop: got %0d beats (before %0d) required last (0,A0)",
                     bchan.size(), n);
        end
        compared++;
        if (ndone != 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL cont_end: got pulses=%0d busy=%b required 1/0",
                     ndone, busy);
        end
    endtask
`endif

    initial begin
        compared = 0;
        mismatched = 0;
        cyc = 0;
        ndone = 0;
        bothhigh = 0;
        selbad = 0;
        chk_sel = 1'b0;
        dmem[0] = 8'hA0;
        dmem[1] = 8'hB1;
        dmem[2] = 8'hC2;
        dmem[3] = 8'hD3;
        test_reset();
        test_single_pass();
        test_sparse();
        test_backpressure();
        test_empty();
        test_ignored_start();
        test_reset_mid();
`ifdef SCAN_CONT_EN
        test_cont();
`endif
        compared++;
        if (bothhigh != 0) begin
            mismatched++;
            $display("FAIL done_busy_overlap: got %0d cycles required 0",
                     bothhigh);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
